// File: rtl/sdtx_block_sched.sv
// Block scheduler for the SD transmit path: prefetches buffer words into a
// 2-entry FIFO and streams them block by block with an idle gap before each.
module sdtx_block_sched #(
  parameter int LGMEM = 10,
  parameter int LGBLK = 10,
  parameter int LGGAP = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [LGBLK-1:0] i_blk_words,
  input  logic [15:0]      i_blk_count,
  input  logic [LGMEM-1:0] i_base,
  input  logic [LGGAP-1:0] i_gap,
  input  logic [1:0]       i_width,
  input  logic             i_ddr,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_rd_en,
  output logic [LGMEM-1:0] o_rd_addr,
  input  logic [31:0]      i_rd_data,
  output logic             o_en,
  output logic [1:0]       o_width,
  output logic             o_ddr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic             o_last,
  input  logic             i_tx_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_DATA, S_DRAIN} state_t;

  state_t           state;
  logic [LGBLK-1:0] blk_words;
  logic [LGBLK-1:0] issue_left;
  logic [15:0]      blk_left;
  logic [LGGAP-1:0] gap;
  logic [LGGAP-1:0] gap_cnt;
  logic             drain_first;
  logic             aborted;
  logic             rd_vld_p1;
  logic             rd_last_p1;
  logic [31:0]      fifo_data [2];
  logic [1:0]       fifo_last;
  logic [1:0]       fifo_cnt;
  logic             hd;
  logic             pop;
  logic             push;
  logic             wr_ptr;
  logic             bad_req;
  logic [1:0]       occ_after;

  assign o_valid   = (state == S_DATA) && (fifo_cnt != 2'd0);
  assign o_data    = o_valid ? fifo_data[hd] : '0;
  assign o_last    = o_valid && fifo_last[hd];
  assign pop       = o_valid && i_ready;
  assign push      = rd_vld_p1;
  assign wr_ptr    = hd ^ fifo_cnt[0];
  assign bad_req   = (i_blk_words == '0) || (i_blk_count == 16'd0) || (i_width == 2'd3);
  // Counting the same-cycle pop lets a new read issue every cycle at full rate.
  assign occ_after = fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
  assign o_rd_en   = ((state == S_GAP) || (state == S_DATA)) && (issue_left != '0)
                     && (occ_after < 2'd2) && !i_abort;

  // Stage p1 -> FIFO: RAM data lands one cycle after the read strobe
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_rd_data;
      fifo_last[wr_ptr] <= rd_last_p1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_en        <= 1'b0;
      o_width     <= 2'd0;
      o_ddr       <= 1'b0;
      o_rd_addr   <= '0;
      blk_words   <= '0;
      issue_left  <= '0;
      blk_left    <= 16'd0;
      gap         <= '0;
      gap_cnt     <= '0;
      drain_first <= 1'b0;
      aborted     <= 1'b0;
      rd_vld_p1   <= 1'b0;
      rd_last_p1  <= 1'b0;
      fifo_cnt    <= 2'd0;
      hd          <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      rd_vld_p1  <= o_rd_en;
      rd_last_p1 <= (issue_left == LGBLK'(1));
      if (o_rd_en) begin
        o_rd_addr  <= o_rd_addr + LGMEM'(1);
        issue_left <= issue_left - LGBLK'(1);
      end
      if (push && !pop)
        fifo_cnt <= fifo_cnt + 2'd1;
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - 2'd1;
      if (pop)
        hd <= ~hd;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (bad_req) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              blk_words   <= i_blk_words;
              issue_left  <= i_blk_words;
              blk_left    <= i_blk_count;
              gap         <= i_gap;
              gap_cnt     <= i_gap;
              o_rd_addr   <= i_base;
              o_width     <= i_width;
              o_ddr       <= i_ddr;
              o_en        <= 1'b1;
              o_busy      <= 1'b1;
              aborted     <= 1'b0;
              drain_first <= 1'b0;
              state       <= (i_gap == '0) ? S_DATA : S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - LGGAP'(1);
          if (gap_cnt == LGGAP'(1))
            state <= S_DATA;
        end
        S_DATA: begin
          if (pop && fifo_last[hd]) begin
            state       <= S_DRAIN;
            drain_first <= 1'b1;
          end
        end
        S_DRAIN: begin
          aborted <= aborted | i_abort;
          // The datapath needs a cycle to raise i_tx_busy for the final word.
          if (drain_first) begin
            drain_first <= 1'b0;
          end else if (!i_tx_busy) begin
            if (aborted || i_abort || (blk_left == 16'd1)) begin
              o_done  <= 1'b1;
              o_err   <= aborted | i_abort;
              o_busy  <= 1'b0;
              o_en    <= 1'b0;
              o_width <= 2'd0;
              o_ddr   <= 1'b0;
              state   <= S_IDLE;
            end else begin
              blk_left   <= blk_left - 16'd1;
              issue_left <= blk_words;
              gap_cnt    <= gap;
              state      <= (gap == '0) ? S_DATA : S_GAP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (i_abort && ((state == S_GAP) || (state == S_DATA))) begin
        state       <= S_DRAIN;
        drain_first <= 1'b1;
        aborted     <= 1'b1;
        fifo_cnt    <= 2'd0;
        rd_vld_p1   <= 1'b0;
        issue_left  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdtx_block_sched.sv
// Directed bench for sdtx_block_sched: table of transfers plus hand-written
// abort and reset sequences, against a RAM model with RAM[a] = C0DE0000 ^ a.
module tb_sdtx_block_sched;
  localparam int LGMEM = 10;
  localparam int LGBLK = 10;
  localparam int LGGAP = 8;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_start;
  logic [LGBLK-1:0] i_blk_words;
  logic [15:0]      i_blk_count;
  logic [LGMEM-1:0] i_base;
  logic [LGGAP-1:0] i_gap;
  logic [1:0]       i_width;
  logic             i_ddr;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic             o_rd_en;
  logic [LGMEM-1:0] o_rd_addr;
  logic [31:0]      i_rd_data;
  logic             o_en;
  logic [1:0]       o_width;
  logic             o_ddr;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_data;
  logic             o_last;
  logic             i_tx_busy;

  int    errors = 0;
  int    checks = 0;
  string tcur   = "init";

  typedef struct {
    string name;
    int words, count, base, gap, width, ddr;
    int rnd, hold, mid_start;
    int err, lat;
  } vec_t;
  vec_t tbl [9];

  sdtx_block_sched #(.LGMEM(LGMEM), .LGBLK(LGBLK), .LGGAP(LGGAP)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_blk_words(i_blk_words), .i_blk_count(i_blk_count), .i_base(i_base),
    .i_gap(i_gap), .i_width(i_width), .i_ddr(i_ddr), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_en(o_en),
    .o_width(o_width), .o_ddr(o_ddr), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .i_tx_busy(i_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ram_word(input logic [LGMEM-1:0] a);
    return 32'hC0DE_0000 ^ {22'd0, a};
  endfunction

  always @(posedge i_clk) if (o_rd_en) i_rd_data <= ram_word(o_rd_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tcur, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic start_cfg(input int words, input int count, input int base, input int gap,
                           input int width, input int ddr);
    i_blk_words = LGBLK'(words);
    i_blk_count = 16'(count);
    i_base      = LGMEM'(base);
    i_gap       = LGGAP'(gap);
    i_width     = 2'(width);
    i_ddr       = 1'(ddr);
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int acc, iss, blk, exp_first, exp_done, hold_left, tx_fall, last_cyc, drain_end, lasts;
    bit blk_seen, hold_on, done_seen, stall, exp_lst;
    logic [31:0] held;
    logic [LGMEM-1:0] a;
    acc = 0; iss = 0; blk = 0; exp_first = v.lat; exp_done = -1; hold_left = 0;
    tx_fall = -1; last_cyc = -1; drain_end = -1; lasts = 0;
    blk_seen = 0; hold_on = 0; done_seen = 0; stall = 0; held = '0;
    tcur = v.name;
    i_ready = 1'b1; i_tx_busy = 1'b0; i_abort = 1'b0;
    start_cfg(v.words, v.count, v.base, v.gap, v.width, v.ddr);
    if (v.err != 0) begin
      #1;
      chk("bad_done", 32'(o_done), 32'd1);
      chk("bad_err", 32'(o_err), 32'd1);
      chk("bad_busy", 32'(o_busy), 32'd0);
      chk("bad_en", 32'(o_en), 32'd0);
      tick();
      #1;
      chk("bad_done_pulse", 32'(o_done), 32'd0);
      chk("bad_busy_after", 32'(o_busy), 32'd0);
      return;
    end
    for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
      i_start     = (cyc == v.mid_start);
      i_width     = i_start ? 2'd3 : 2'(v.width);
      i_blk_count = i_start ? 16'd0 : 16'(v.count);
      i_ready     = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_on && drain_end >= 0 && cyc > drain_end) hold_on = 0;
      if (hold_on) begin
        if (hold_left > 0) begin
          i_tx_busy = 1'b1;
          hold_left--;
        end else begin
          i_tx_busy = 1'b0;
          if (tx_fall < 0) begin
            tx_fall   = cyc;
            drain_end = (tx_fall > last_cyc + 2) ? tx_fall : last_cyc + 2;
            if (blk == v.count) exp_done = drain_end + 1;
            else exp_first = drain_end + v.lat;
          end
        end
      end else begin
        i_tx_busy = blk_seen;
      end
      #1;
      if (cyc == exp_done) begin
        chk("done", 32'(o_done), 32'd1);
        chk("done_err", 32'(o_err), 32'd0);
        chk("done_en", 32'(o_en), 32'd0);
        chk("done_busy", 32'(o_busy), 32'd0);
        chk("done_width", 32'(o_width), 32'd0);
        chk("done_ddr", 32'(o_ddr), 32'd0);
        done_seen = 1;
      end else begin
        chk("no_done", 32'(o_done), 32'd0);
        chk("en_held", 32'(o_en), 32'd1);
        chk("busy_held", 32'(o_busy), 32'd1);
        chk("width_held", 32'(o_width), 32'(v.width));
        chk("ddr_held", 32'(o_ddr), 32'(v.ddr));
      end
      if (o_rd_en) begin
        a = LGMEM'(v.base) + LGMEM'(iss);
        chk("rd_addr", 32'(o_rd_addr), 32'(a));
        iss++;
      end
      if (stall) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", o_data, held);
      end
      if (o_valid && !blk_seen) begin
        chk("first_valid_cyc", 32'(cyc), 32'(exp_first));
        blk_seen = 1;
      end
      if (o_valid) begin
        a = LGMEM'(v.base) + LGMEM'(acc);
        exp_lst = ((acc % v.words) == v.words - 1);
        chk("data", o_data, ram_word(a));
        chk("last", 32'(o_last), 32'(exp_lst));
        if (i_ready) begin
          if (o_last) lasts++;
          if (exp_lst) begin
            blk++;
            blk_seen  = 0;
            hold_on   = 1;
            hold_left = v.hold;
            tx_fall   = -1;
            drain_end = -1;
            last_cyc  = cyc;
            exp_first = -1;
          end
          acc++;
        end
      end
      chk("outstanding_le2", 32'((iss - acc) <= 2), 32'd1);
      stall = o_valid && !i_ready;
      held  = o_data;
      tick();
    end
    i_start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("words_total", 32'(acc), 32'(v.words * v.count));
    chk("last_pulses", 32'(lasts), 32'(v.count));
  endtask

  task automatic run_abort();
    int acc, ab;
    bit seen_done;
    acc = 0; ab = -1; seen_done = 0;
    tcur = "abort";
    i_ready = 1'b1; i_tx_busy = 1'b1; i_abort = 1'b0;
    start_cfg(8, 1, 'h20, 0, 1, 0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      i_abort = (ab < 0 && acc == 2);
      if (i_abort) ab = cyc;
      i_tx_busy = (ab < 0 || cyc < ab + 6);
      #1;
      if (ab >= 0 && cyc == ab + 7) begin
        chk("abort_done", 32'(o_done), 32'd1);
        chk("abort_err", 32'(o_err), 32'd1);
        chk("abort_en", 32'(o_en), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        seen_done = 1;
      end else begin
        chk("abort_no_done", 32'(o_done), 32'd0);
      end
      if (ab >= 0 && cyc > ab && cyc < ab + 7) begin
        chk("abort_valid_low", 32'(o_valid), 32'd0);
        chk("abort_rd_low", 32'(o_rd_en), 32'd0);
      end
      if (o_valid && !i_abort) begin
        chk("abort_data", o_data, ram_word(LGMEM'('h20 + acc)));
        acc++;
      end
      tick();
      if (seen_done) break;
    end
    i_abort = 1'b0;
    i_tx_busy = 1'b0;
    chk("abort_done_seen", 32'(seen_done), 32'd1);
    chk("abort_words", 32'(acc), 32'd2);
  endtask

  task automatic run_reset_mid();
    tcur = "reset_mid";
    i_ready = 1'b1; i_tx_busy = 1'b1; i_abort = 1'b0;
    start_cfg(8, 1, 'h40, 0, 2, 1);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      i_reset_n = (cyc != 4);
      #1;
      if (cyc == 4) chk("pre_valid", 32'(o_valid), 32'd1);
      if (cyc >= 5) begin
        chk("valid", 32'(o_valid), 32'd0);
        chk("en", 32'(o_en), 32'd0);
        chk("busy", 32'(o_busy), 32'd0);
        chk("rd_en", 32'(o_rd_en), 32'd0);
        chk("done", 32'(o_done), 32'd0);
        chk("width", 32'(o_width), 32'd0);
      end
      tick();
    end
    i_reset_n = 1'b1;
    i_tx_busy = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"single",     4, 1, 'h10,  3, 1, 0, 0, 3, 0, 0, 4};
    tbl[1] = '{"multi_wrap", 3, 2, 1022,  0, 2, 1, 0, 2, 0, 0, 3};
    tbl[2] = '{"backpress",  8, 1, 'h100, 1, 0, 1, 1, 1, 0, 0, 3};
    tbl[3] = '{"drain_1st",  2, 3, 'h3F0, 2, 1, 0, 0, 0, 0, 0, 3};
    tbl[4] = '{"mid_start",  5, 1, 7,     5, 2, 0, 0, 4, 6, 0, 6};
    tbl[5] = '{"bad_count",  4, 0, 0,     0, 1, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{"bad_words",  0, 1, 0,     0, 1, 0, 0, 0, 0, 1, 0};
    tbl[7] = '{"bad_width",  4, 1, 0,     0, 3, 0, 0, 0, 0, 1, 0};
    tbl[8] = '{"long_gap",   1, 2, 'h55,  7, 0, 1, 0, 1, 0, 0, 8};

    i_reset_n = 1'b0; i_start = 1'b0; i_blk_words = '0; i_blk_count = '0;
    i_base = '0; i_gap = '0; i_width = '0; i_ddr = 1'b0; i_abort = 1'b0;
    i_ready = 1'b0; i_tx_busy = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    tcur = "reset";
    chk("busy", 32'(o_busy), 32'd0);
    chk("done", 32'(o_done), 32'd0);
    chk("en", 32'(o_en), 32'd0);
    chk("valid", 32'(o_valid), 32'd0);
    chk("rd_en", 32'(o_rd_en), 32'd0);
    chk("rd_addr", 32'(o_rd_addr), 32'd0);
    chk("data", o_data, 32'd0);
    chk("last", 32'(o_last), 32'd0);
    tick();

    for (int i = 0; i < 9; i++) run_xfer(tbl[i]);
    run_abort();
    run_reset_mid();
    tbl[0].name = "after_reset";
    run_xfer(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
